// File: rtl/l1_fmap_streamer.sv
// l1_fmap_streamer
//   Streams DEPTH words of the layer-1 feature map out of the layer memory
//   onto a valid/ready stream. While streaming it accumulates the unsigned
//   sum and the maximum of every transferred word.
//
//   Ports
//     clk       : clock, all state on the rising edge
//     reset     : asynchronous active-low reset
//     start     : one-cycle request to begin a run (ignored unless idle)
//     busy      : run in progress (READ or DRAIN)
//     crd       : layer memory read strobe
//     csel      : layer memory select, 1 while busy
//     caddr_rd  : layer memory read address (upper bits always 0)
//     cdata_rd  : read data, returned the cycle after crd
//     m_data    : streamed word (0 when m_valid is low)
//     m_valid   : m_data valid
//     m_ready   : downstream accepts
//     m_last    : marks the final word of the run
//     max_val   : running maximum of transferred words
//     sum_val   : running sum of transferred words
//     done      : one-cycle completion pulse
module l1_fmap_streamer #(
    parameter int DEPTH = 1024,
    parameter int DW    = 13,
    parameter int SW    = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          crd,
    output logic          csel,
    output logic [11:0]   caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [DW-1:0] max_val,
    output logic [SW-1:0] sum_val,
    output logic          done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [AW-1:0]   xfer_q,  xfer_d;
    logic            pend_q,  pend_d;
    logic [DW-1:0]   ent0_q,  ent0_d;
    logic [DW-1:0]   ent1_q,  ent1_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q,   cnt_d;
    logic [DW-1:0]   max_q,   max_d;
    logic [SW-1:0]   sum_q,   sum_d;

    logic [DW-1:0]   head;
    logic            pop;
    logic            push;
    logic            issue;
    logic            last_word;
    logic [2:0]      level;

    always_comb begin
        head      = rd_ptr_q ? ent1_q : ent0_q;
        m_valid   = (cnt_q != 2'd0);
        m_data    = m_valid ? head : '0;
        pop       = m_valid & m_ready;
        push      = pend_q;
        last_word = (xfer_q == AW'(DEPTH - 1));
        m_last    = m_valid & last_word;

        // Occupancy counts the word leaving this cycle as already gone, so a
        // new read can be issued while the head is being accepted. Without
        // that credit the one-cycle read latency halves the throughput.
        level     = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
        issue     = (state_q == S_READ) && (level < 3'd2);

        crd       = issue;
        caddr_rd  = issue ? 12'(addr_q) : '0;
        busy      = (state_q == S_READ) || (state_q == S_DRAIN);
        csel      = busy;
        done      = (state_q == S_FIN);
        max_val   = max_q;
        sum_val   = sum_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        xfer_d   = xfer_q;
        pend_d   = issue;
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        max_d    = max_q;
        sum_d    = sum_q;

        if (push) begin
            if (wr_ptr_q) begin
                ent1_d = cdata_rd;
            end else begin
                ent0_d = cdata_rd;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            xfer_d   = xfer_q + 1'b1;
            sum_d    = sum_q + SW'(head);
            if (head > max_q) begin
                max_d = head;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    xfer_d  = '0;
                    max_d   = '0;
                    sum_d   = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == AW'(DEPTH - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && last_word) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            xfer_q   <= '0;
            pend_q   <= 1'b0;
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            xfer_q   <= xfer_d;
            pend_q   <= pend_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            sum_q    <= sum_d;
        end
    end

endmodule

// File: tb/tb_l1_fmap_streamer.sv
// tb_l1_fmap_streamer
//   Directed bench for l1_fmap_streamer: a table of whole-run vectors
//   (memory pattern, ready behaviour, start spamming, expected sum/max)
//   plus hand-written stall and reset sequences.
module tb_l1_fmap_streamer;

    localparam int DEPTH = 1024;
    localparam int DW    = 13;
    localparam int SW    = 23;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          crd;
    logic          csel;
    logic [11:0]   caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [DW-1:0] max_val;
    logic [SW-1:0] sum_val;
    logic          done;

    l1_fmap_streamer #(.DEPTH(DEPTH), .DW(DW), .SW(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .crd      (crd),
        .csel     (csel),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .max_val  (max_val),
        .sum_val  (sum_val),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    // Layer memory: data for a read presented in one cycle is returned in the next.
    always @(posedge clk) begin
        if (crd) cdata_rd <= mem[caddr_rd[9:0]];
    end

    typedef struct {
        int pat;
        int rnd;
        int spam;
        int abort_at;
        int exp_sum;
        int exp_max;
    } vec_t;

    vec_t vt [6];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    busy,     0);
        chk({tag, "_crd"},     crd,      0);
        chk({tag, "_csel"},    csel,     0);
        chk({tag, "_valid"},   m_valid,  0);
        chk({tag, "_last"},    m_last,   0);
        chk({tag, "_done"},    done,     0);
        chk({tag, "_addr"},    caddr_rd, 0);
        chk({tag, "_data"},    m_data,   0);
        chk({tag, "_max"},     max_val,  0);
        chk({tag, "_sum"},     sum_val,  0);
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < DEPTH; i++) begin
            case (pat)
                0:       mem[i] = DW'(i);
                1:       mem[i] = 13'd8191;
                2:       mem[i] = DW'(1023 - i);
                default: mem[i] = (i == 700) ? 13'd5000 : 13'd1;
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v);
        int idx = 0, rd_exp = 0, occ = 0, pend = 0;
        int busy_n = 0, first_v = -1, done_n = 0;
        int unsigned rsum = 0, rmax = 0;
        bit prev_stall = 0, last_prev = 0, fin_seen = 0, pop;
        logic [DW-1:0] prev_data = '0;

        fill(v.pat);
        for (int cyc = 0; cyc < 6000 && !fin_seen; cyc++) begin
            @(negedge clk);
            start   = (cyc == 0) || (v.spam != 0 && (cyc == 300 || cyc == 301 || last_prev));
            m_ready = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 0) begin
                chk("idle_busy", busy, 0);
            end else begin
                chk("csel", csel, busy);
                if (busy) begin
                    if (m_valid && first_v < 0) first_v = busy_n;
                    busy_n++;
                end
                pop = m_valid && m_ready;
                chk("valid", m_valid, (occ != 0));
                if (crd) begin
                    chk("rd_addr", caddr_rd, rd_exp);
                    chk("rd_credit", ((occ + pend - int'(pop)) < 2), 1);
                    rd_exp++;
                end
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                end
                if (m_valid) begin
                    chk("data", m_data, mem[idx % DEPTH]);
                    chk("last", m_last, (idx == DEPTH - 1));
                end
                chk("sum_run", sum_val, rsum);
                chk("max_run", max_val, rmax);
                chk("done", done, last_prev);
                if (done) begin
                    done_n++;
                    fin_seen = 1;
                    chk("fin_busy", busy, 0);
                    chk("fin_count", idx, DEPTH);
                end
                if (v.abort_at > 0 && idx == v.abort_at) begin
                    reset = 1'b0;
                    #1;
                    chk_zero("abort");
                    @(negedge clk);
                    #1;
                    chk_zero("abort_hold");
                    @(negedge clk);
                    reset   = 1'b1;
                    start   = 1'b0;
                    m_ready = 1'b0;
                    return;
                end
                last_prev = pop && (idx == DEPTH - 1);
                if (pop) begin
                    rsum += mem[idx];
                    if (mem[idx] > rmax) rmax = mem[idx];
                    idx++;
                end
                occ        = occ + pend - int'(pop);
                pend       = int'(crd);
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
        chk("complete", fin_seen, 1);
        chk("reads", rd_exp, DEPTH);
        chk("done_pulses", done_n, 1);
        if (v.rnd == 0) begin
            chk("busy_cycles", busy_n, DEPTH + 2);
            chk("first_valid", first_v, 2);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("post_busy", busy, 0);
            chk("post_done", done, 0);
            chk("hold_sum", sum_val, v.exp_sum);
            chk("hold_max", max_val, v.exp_max);
        end
    endtask

    initial begin
        int nrd;
        reset   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        fill(0);

        vt[0] = '{0, 0, 0, 0,   523776,  1023};
        vt[1] = '{1, 0, 0, 0,   8387584, 8191};
        vt[2] = '{0, 1, 0, 0,   523776,  1023};
        vt[3] = '{2, 1, 1, 0,   523776,  1023};
        vt[4] = '{3, 0, 0, 500, 0,       0};
        vt[5] = '{3, 0, 1, 0,   6023,    5000};

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Downstream stalled from the start: only two reads may be in the pipe.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nrd = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (crd) begin
                chk("stall_rd_addr", caddr_rd, nrd);
                nrd++;
            end
            @(negedge clk);
        end
        #1;
        chk("stall_reads", nrd, 2);
        chk("stall_hold_valid", m_valid, 1);
        chk("stall_hold_word", m_data, 0);
        chk("stall_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk_zero("stall_reset");
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 6; n++) begin
            run_vec(vt[n]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
